// File: rtl/rf_writeback_if.sv
// Result channels from EXU and LSU into the writeback stage, plus the GPR file write port.
// slave = the writeback block, master = the producers / GPR file side.
interface rf_writeback_if #(
    parameter int XLEN = 64
);
    logic            exu_valid;
    logic            exu_ready;
    logic [4:0]      exu_rd;
    logic [XLEN-1:0] exu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic [4:0]      rf_waddr;
    logic            rf_wen;
    logic [XLEN-1:0] rf_wdata;

    modport slave (
        input  exu_valid, exu_rd, exu_data,
        output exu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_waddr, rf_wen, rf_wdata
    );

    modport master (
        output exu_valid, exu_rd, exu_data,
        input  exu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_waddr, rf_wen, rf_wdata
    );
endinterface

// File: rtl/rf_writeback.sv
// GPR writeback: arbitrates EXU/LSU results onto one registered write port and keeps a
// per-register pending-write scoreboard for issue RAW stalls. Optional: RF_WB_BYPASS_EN.
module rf_writeback #(
    parameter int XLEN       = 64,
    parameter int CNT_W      = 2,
    parameter int LSU_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    rf_writeback_if.slave wb,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        q_busy1,
    output logic        q_busy2
`ifdef RF_WB_BYPASS_EN
    ,
    output logic            byp1_hit,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp1_data,
    output logic [XLEN-1:0] byp2_data
`endif
);

    localparam int              SW      = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   S_LIMIT = SW'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SW-1:0] starve_q, starve_d;
    logic          hi_valid, lo_valid, hi_ready, lo_ready, force_lo;
    logic          exu_fire, lsu_fire, fire;
    logic [4:0]    win_rd;
    logic [XLEN-1:0] win_data;

    // Map EXU/LSU onto priority (hi) / starvation-protected (lo) roles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hi_valid     = (LSU_PRIO != 0) ? wb.lsu_valid : wb.exu_valid;
        lo_valid     = (LSU_PRIO != 0) ? wb.exu_valid : wb.lsu_valid;
        force_lo     = (starve_q == S_LIMIT);
        hi_ready     = !lo_valid || !force_lo;
        lo_ready     = !hi_valid || force_lo;
        wb.exu_ready = (LSU_PRIO != 0) ? lo_ready : hi_ready;
        wb.lsu_ready = (LSU_PRIO != 0) ? hi_ready : lo_ready;
        starve_d     = (lo_valid && !lo_ready) ? starve_q + SW'(1) : '0;
    end

    assign exu_fire = wb.exu_valid && wb.exu_ready;
    assign lsu_fire = wb.lsu_valid && wb.lsu_ready;
    assign fire     = exu_fire || lsu_fire;
    assign win_rd   = lsu_fire ? wb.lsu_rd   : wb.exu_rd;
    assign win_data = lsu_fire ? wb.lsu_data : wb.exu_data;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            starve_q    <= '0;
            wb.rf_wen   <= 1'b0;
            wb.rf_waddr <= '0;
            wb.rf_wdata <= '0;
        end else begin
            starve_q  <= starve_d;
            wb.rf_wen <= fire && (win_rd != 5'd0);
            if (fire) begin
                wb.rf_waddr <= win_rd;
                wb.rf_wdata <= win_data;
            end
        end
    end

    // Scoreboard: one pending counter per GPR; x0 stays at zero.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             inc_en, dec_en;
    logic [31:0]      inc_vec, dec_vec;

    assign dec_en    = wb.rf_wen && (wb.rf_waddr != 5'd0);
    assign iss_ready = !((cnt_q[iss_rd] == CNT_MAX) && !(dec_en && (wb.rf_waddr == iss_rd)));
    assign inc_en    = iss_valid && iss_ready && (iss_rd != 5'd0);
    assign inc_vec   = inc_en ? (32'd1 << iss_rd) : 32'd0;
    assign dec_vec   = dec_en ? (32'd1 << wb.rf_waddr) : 32'd0;

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            // A decrement of an empty counter is dropped; the check below flags it.
            case ({inc_vec[i], dec_vec[i] && (cnt_q[i] != '0)})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the counter array is reset because reset must drop every outstanding reservation.
        if (reset) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && dec_en)
            assert (cnt_q[wb.rf_waddr] != '0)
            else $error("rf_writeback: write of x%0d with no pending reservation", wb.rf_waddr);
    end
`endif

    logic busy1_raw, busy2_raw;
    assign busy1_raw = (cnt_q[q_rs1] != '0);
    assign busy2_raw = (cnt_q[q_rs2] != '0);

`ifdef RF_WB_BYPASS_EN
    // Last pending write is on the port now: forward it and drop the stall a cycle early.
    assign byp1_hit  = wb.rf_wen && (wb.rf_waddr == q_rs1) && (q_rs1 != 5'd0);
    assign byp2_hit  = wb.rf_wen && (wb.rf_waddr == q_rs2) && (q_rs2 != 5'd0);
    assign byp1_data = wb.rf_wdata;
    assign byp2_data = wb.rf_wdata;
    assign q_busy1   = busy1_raw && !(byp1_hit && (cnt_q[q_rs1] == CNT_ONE));
    assign q_busy2   = busy2_raw && !(byp2_hit && (cnt_q[q_rs2] == CNT_ONE));
`else
    assign q_busy1   = busy1_raw;
    assign q_busy2   = busy2_raw;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback (XLEN=64, CNT_W=2, LSU_PRIO=1, STARVE_MAX=4);
// builds with or without RF_WB_BYPASS_EN.
module tb_rf_writeback;
    localparam int XLEN = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rf_writeback_if #(.XLEN(XLEN)) wb ();

    logic       iss_valid, iss_ready;
    logic [4:0] iss_rd, q_rs1, q_rs2;
    logic       q_busy1, q_busy2;
`ifdef RF_WB_BYPASS_EN
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp1_data, byp2_data;
`endif

    rf_writeback #(
        .XLEN(XLEN), .CNT_W(2), .LSU_PRIO(1), .STARVE_MAX(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wb        (wb),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp1_hit  (byp1_hit),
        .byp2_hit  (byp2_hit),
        .byp1_data (byp1_data),
        .byp2_data (byp2_data)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there or 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wb.exu_valid = 1'b0; wb.exu_rd = '0; wb.exu_data = '0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic reserve(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd = rd;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        idle();
        q_rs1 = '0; q_rs2 = '0;

        // Reset held two edges with both producers valid.
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd1; wb.exu_data = 64'h11;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd2; wb.lsu_data = 64'h22;
        tick(); tick();
        check("reset_wen", wb.rf_wen, 1'b0);
        check("reset_waddr", wb.rf_waddr, 5'd0);
        check("reset_wdata", wb.rf_wdata, 64'd0);
        reset = 1'b0;
        idle();
        q_rs1 = 5'd1; q_rs2 = 5'd2; iss_rd = 5'd1;
        settle();
        check("post_reset_busy1", q_busy1, 1'b0);
        check("post_reset_busy2", q_busy2, 1'b0);
        check("post_reset_iss_ready", iss_ready, 1'b1);
        tick();
        check("idle_wen", wb.rf_wen, 1'b0);

        // Single EXU write of x5.
        reserve(5'd5);
        q_rs1 = 5'd5;
        settle();
        check("x5_busy_reserved", q_busy1, 1'b1);
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd5; wb.exu_data = 64'hDEAD_BEEF;
        settle();
        check("x5_exu_ready", wb.exu_ready, 1'b1);
        tick();
        wb.exu_valid = 1'b0;
        check("x5_wen", wb.rf_wen, 1'b1);
        check("x5_waddr", wb.rf_waddr, 5'd5);
        check("x5_wdata", wb.rf_wdata, 64'hDEAD_BEEF);
        tick();
        check("x5_wen_drop", wb.rf_wen, 1'b0);
        check("x5_busy_clear", q_busy1, 1'b0);

        // Conflict: LSU (priority, rd=0) vs EXU (rd=11) held valid.
        reserve(5'd11);
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd11; wb.exu_data = 64'h1111;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0;  wb.lsu_data = 64'h2222;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("arb_c%0d_lsu_ready", c), wb.lsu_ready, 1'b1);
            check($sformatf("arb_c%0d_exu_ready", c), wb.exu_ready, 1'b0);
            tick();
            check($sformatf("arb_c%0d_rd0_no_wen", c), wb.rf_wen, 1'b0);
        end
        settle();
        check("arb_c5_exu_ready", wb.exu_ready, 1'b1);
        check("arb_c5_lsu_ready", wb.lsu_ready, 1'b0);
        tick();
        check("arb_exu_wen", wb.rf_wen, 1'b1);
        check("arb_exu_waddr", wb.rf_waddr, 5'd11);
        check("arb_exu_wdata", wb.rf_wdata, 64'h1111);
        check("arb_c6_lsu_ready", wb.lsu_ready, 1'b1);
        check("arb_c6_exu_ready", wb.exu_ready, 1'b0);
        idle();
        tick();

        // Saturate x7 (max 3 pending), then drain it with three writes.
        q_rs1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1'b1; iss_rd = 5'd7;
            settle();
            check($sformatf("x7_iss%0d_ready", k), iss_ready, 1'b1);
            tick();
        end
        settle();
        check("x7_iss_full", iss_ready, 1'b0);
        tick();
        iss_valid = 1'b0;
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd7; wb.exu_data = 64'hA1;
        tick();
        wb.exu_data = 64'hA2;
        settle();
        check("x7_commit_frees", iss_ready, 1'b1);
        check("x7_busy_w1", q_busy1, 1'b1);
        tick();
        wb.exu_data = 64'hA3;
        settle();
        check("x7_busy_w2", q_busy1, 1'b1);
        tick();
        wb.exu_valid = 1'b0;
        check("x7_w3_wdata", wb.rf_wdata, 64'hA3);
`ifdef RF_WB_BYPASS_EN
        check("x7_busy_w3_byp", q_busy1, 1'b0);
`else
        check("x7_busy_w3", q_busy1, 1'b1);
`endif
        tick();
        check("x7_busy_drained", q_busy1, 1'b0);
        check("x7_wen_drop", wb.rf_wen, 1'b0);

        // Same-edge reserve and commit of x3 at cnt=1.
        reserve(5'd3);
        q_rs2 = 5'd3;
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd3; wb.exu_data = 64'h33;
        tick();
        wb.exu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd3;
        settle();
        check("x3_iss_ready", iss_ready, 1'b1);
        tick();
        iss_valid = 1'b0;
        settle();
        check("x3_busy_net", q_busy2, 1'b1);
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd3; wb.exu_data = 64'h34;
        tick();
        wb.exu_valid = 1'b0;
        tick();
        check("x3_busy_clear", q_busy2, 1'b0);

        // rd=0 completes the handshake but never writes.
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd0; wb.exu_data = 64'h55;
        settle();
        check("x0_exu_ready", wb.exu_ready, 1'b1);
        tick();
        wb.exu_valid = 1'b0;
        check("x0_no_wen", wb.rf_wen, 1'b0);

        // Query of x9 while its only pending write is on the port.
        reserve(5'd9);
        q_rs1 = 5'd9; q_rs2 = 5'd0;
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd9; wb.exu_data = 64'h9999;
        tick();
        wb.exu_valid = 1'b0;
        settle();
`ifdef RF_WB_BYPASS_EN
        check("x9_byp1_hit", byp1_hit, 1'b1);
        check("x9_byp1_data", byp1_data, 64'h9999);
        check("x9_byp2_hit_rs0", byp2_hit, 1'b0);
        check("x9_busy1_masked", q_busy1, 1'b0);
`else
        check("x9_busy1_during_write", q_busy1, 1'b1);
`endif
        check("x9_busy2_rs0", q_busy2, 1'b0);
        tick();
        check("x9_busy1_after", q_busy1, 1'b0);

        // Reset while a write is in flight drops it and all reservations.
        reserve(5'd12);
        reserve(5'd12);
        q_rs1 = 5'd12;
        wb.exu_valid = 1'b1; wb.exu_rd = 5'd12; wb.exu_data = 64'hC0;
        tick();
        check("x12_inflight_wen", wb.rf_wen, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("x12_reset_drop_wen", wb.rf_wen, 1'b0);
        check("x12_reset_busy", q_busy1, 1'b0);
        tick();
        check("x12_after_reset_wen", wb.rf_wen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
